// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display with a double-buffered display word.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] disp_data,
   input  logic [7:0]  disp_dp,
   input  logic        disp_load,
   input  logic [7:0]  dig_en,
   output logic        load_pending,
   output logic [3:0]  nib_out,
   input  logic [7:0]  seg_in,
   output logic [7:0]  seg_out,
   output logic [7:0]  an,
   output logic        frame_tick
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [31:0]   shadow_data;
   logic [7:0]    shadow_dp;
   logic [31:0]   active_data;
   logic [7:0]    active_dp;
   logic          slot_end;
   logic          frame_bnd;
   logic [7:0]    lz_dark;
   logic          dark;
   logic          unused_seg_dp;

   assign slot_end  = (cnt == CNT_MAX);
   assign frame_bnd = slot_end && (idx == 3'd7);

   // The decoder's own dp bit is replaced by the per-digit decimal point.
   assign unused_seg_dp = seg_in[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= 3'd0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_bnd;
         if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // A load landing on the boundary cycle still promotes the older shadow word;
   // the new one waits a full frame, so a frame never mixes two words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_data  <= '0;
         shadow_dp    <= '0;
         active_data  <= '0;
         active_dp    <= '0;
         load_pending <= 1'b0;
      end else begin
         if (frame_bnd && load_pending) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
         end
         if (disp_load) begin
            shadow_data  <= disp_data;
            shadow_dp    <= disp_dp;
            load_pending <= 1'b1;
         end else if (frame_bnd) begin
            load_pending <= 1'b0;
         end
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   logic nz_above;

   always_comb begin
      lz_dark  = '0;
      nz_above = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         nz_above   = nz_above | (active_data[4*i +: 4] != 4'h0);
         lz_dark[i] = ~nz_above;
      end
   end
`else
   assign lz_dark = '0;
`endif

   assign dark = (cnt < BLANK_END) || !dig_en[idx] || lz_dark[idx];

   // Registered anodes trail idx by a cycle; the blank window hides that lag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an <= 8'hFF;
      end else if (dark) begin
         an <= 8'hFF;
      end else begin
         an <= ~(8'h01 << idx);
      end
   end

   assign nib_out = active_data[4*idx +: 4];
   assign seg_out = {~active_dp[idx], seg_in[6:0]};

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1 (32-cycle frame).
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] disp_data = '0;
   logic [7:0]  disp_dp = '0;
   logic        disp_load = 1'b0;
   logic [7:0]  dig_en = 8'hFF;
   logic        load_pending;
   logic [3:0]  nib_out;
   logic [7:0]  seg_in = 8'h5A;
   logic [7:0]  seg_out;
   logic [7:0]  an;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int ncyc;

   seg7_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .disp_dp(disp_dp),
      .disp_load(disp_load), .dig_en(dig_en), .load_pending(load_pending),
      .nib_out(nib_out), .seg_in(seg_in), .seg_out(seg_out), .an(an),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release: cnt = n%4, idx = (n/4)%8.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ncyc <= 0;
      else        ncyc <= ncyc + 1;
   end

   // Anode value expected after edge n: computed from the cnt/idx of the cycle before.
   function automatic logic [7:0] exp_an(input int n, input logic [7:0] lit);
      int c, k;
      if (n == 0) return 8'hFF;
      c = (n - 1) % 4;
      k = ((n - 1) / 4) % 8;
      if (c < 1 || !lit[k]) return 8'hFF;
      return ~(8'h01 << k);
   endfunction

   task automatic wait_phase(input int p);
      int t = 0;
      while ((ncyc % 32) != p && t < 70) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if ((ncyc % 32) != p) begin
         errors++;
         $display("FAIL wait_phase: phase %0d, required %0d", ncyc % 32, p);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks += 5;
      if (an !== 8'hFF)        begin errors++; $display("FAIL reset_an: got %h, exp FF", an); end
      if (load_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b, exp 0", load_pending); end
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, exp 0", frame_tick); end
      if (nib_out !== 4'h0)    begin errors++; $display("FAIL reset_nib: got %h, exp 0", nib_out); end
      if (seg_out !== 8'hDA)   begin errors++; $display("FAIL reset_seg: got %h, exp DA", seg_out); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_scan;
      for (int i = 0; i < 64; i++) begin
         checks += 3;
         if (an !== exp_an(ncyc, 8'hFF)) begin
            errors++; $display("FAIL scan_an n=%0d: got %h, exp %h", ncyc, an, exp_an(ncyc, 8'hFF));
         end
         if (nib_out !== 4'h0) begin errors++; $display("FAIL scan_nib n=%0d: got %h, exp 0", ncyc, nib_out); end
         if (frame_tick !== (ncyc > 0 && ncyc % 32 == 0)) begin
            errors++; $display("FAIL scan_tick n=%0d: got %b", ncyc, frame_tick);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load;
      logic [3:0] exp_nib [8];
      int k;
      exp_nib = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
      wait_phase(10);
      disp_data = 32'h1234_ABCD; disp_dp = 8'h01; disp_load = 1'b1;
      @(negedge clk);
      disp_load = 1'b0;
      checks++;
      if (load_pending !== 1'b1) begin errors++; $display("FAIL load_pending_set: got %b, exp 1", load_pending); end
      wait_phase(31);
      checks += 2;
      if (load_pending !== 1'b1) begin errors++; $display("FAIL load_pending_hold: got %b, exp 1", load_pending); end
      if (nib_out !== 4'h0) begin errors++; $display("FAIL load_not_early: got %h, exp 0", nib_out); end
      @(negedge clk);
      checks += 2;
      if (load_pending !== 1'b0) begin errors++; $display("FAIL load_pending_clr: got %b, exp 0", load_pending); end
      if (frame_tick !== 1'b1) begin errors++; $display("FAIL load_tick: got %b, exp 1", frame_tick); end
      for (int i = 0; i < 32; i++) begin
         k = (ncyc % 32) / 4;
         checks += 3;
         if (nib_out !== exp_nib[k]) begin errors++; $display("FAIL load_nib idx=%0d: got %h, exp %h", k, nib_out, exp_nib[k]); end
         if (seg_out[7] !== (k != 0)) begin errors++; $display("FAIL load_dp idx=%0d: got %b", k, seg_out[7]); end
         if (seg_out[6:0] !== 7'h5A) begin errors++; $display("FAIL load_seg idx=%0d: got %h, exp 5A", k, seg_out[6:0]); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      wait_phase(8);
      disp_data = 32'h1111_1111; disp_dp = 8'h00; disp_load = 1'b1;
      @(negedge clk);
      disp_load = 1'b0;
      wait_phase(31);
      disp_data = 32'h2222_2222; disp_dp = 8'hFF; disp_load = 1'b1;
      @(negedge clk);
      disp_load = 1'b0;
      checks += 2;
      if (load_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b, exp 1", load_pending); end
      if (seg_out[7] !== 1'b1) begin errors++; $display("FAIL b2b_dp: got %b, exp 1", seg_out[7]); end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (nib_out !== 4'h1) begin errors++; $display("FAIL b2b_first n=%0d: got %h, exp 1", ncyc, nib_out); end
         @(negedge clk);
      end
      wait_phase(31);
      @(negedge clk);
      checks += 3;
      if (load_pending !== 1'b0) begin errors++; $display("FAIL b2b_pending_clr: got %b, exp 0", load_pending); end
      if (nib_out !== 4'h2) begin errors++; $display("FAIL b2b_second: got %h, exp 2", nib_out); end
      if (seg_out[7] !== 1'b0) begin errors++; $display("FAIL b2b_dp2: got %b, exp 0", seg_out[7]); end
   endtask

   task automatic test_dig_en;
      wait_phase(0);
      dig_en = 8'b0000_0101;
      @(negedge clk);
      for (int i = 0; i < 31; i++) begin
         checks++;
         if (an !== exp_an(ncyc, 8'h05)) begin
            errors++; $display("FAIL dig_en_an n=%0d: got %h, exp %h", ncyc, an, exp_an(ncyc, 8'h05));
         end
         @(negedge clk);
      end
      dig_en = 8'hFF;
   endtask

   task automatic test_reset_mid;
      wait_phase(18);
      disp_data = 32'h3333_3333; disp_dp = 8'h00; disp_load = 1'b1;
      @(negedge clk);
      disp_load = 1'b0;
      wait_phase(22);
      checks++;
      if (an !== 8'hDF) begin errors++; $display("FAIL rmid_pre_an: got %h, exp DF", an); end
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (an !== 8'hFF)          begin errors++; $display("FAIL rmid_an: got %h, exp FF", an); end
      if (load_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending: got %b, exp 0", load_pending); end
      if (nib_out !== 4'h0)      begin errors++; $display("FAIL rmid_nib: got %h, exp 0", nib_out); end
      if (frame_tick !== 1'b0)   begin errors++; $display("FAIL rmid_tick: got %b, exp 0", frame_tick); end
      if (seg_out !== 8'hDA)     begin errors++; $display("FAIL rmid_seg: got %h, exp DA", seg_out); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (an !== exp_an(ncyc, 8'hFF)) begin
            errors++; $display("FAIL rmid_scan n=%0d: got %h, exp %h", ncyc, an, exp_an(ncyc, 8'hFF));
         end
         @(negedge clk);
      end
      wait_phase(31);
      @(negedge clk);
      checks += 2;
      if (nib_out !== 4'h0)      begin errors++; $display("FAIL rmid_discard: got %h, exp 0", nib_out); end
      if (load_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending2: got %b, exp 0", load_pending); end
   endtask

   task automatic test_lz;
      logic [7:0] lit_120;
      logic [7:0] lit_0;
`ifdef SEG7_LZ_BLANK_EN
      lit_120 = 8'h07;
      lit_0   = 8'h01;
`else
      lit_120 = 8'hFF;
      lit_0   = 8'hFF;
`endif
      wait_phase(5);
      disp_data = 32'h0000_0120; disp_dp = 8'h00; disp_load = 1'b1;
      @(negedge clk);
      disp_load = 1'b0;
      wait_phase(31);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 31; i++) begin
         checks++;
         if (an !== exp_an(ncyc, lit_120)) begin
            errors++; $display("FAIL lz120_an n=%0d: got %h, exp %h", ncyc, an, exp_an(ncyc, lit_120));
         end
         @(negedge clk);
      end
      wait_phase(5);
      disp_data = 32'h0000_0000; disp_load = 1'b1;
      @(negedge clk);
      disp_load = 1'b0;
      wait_phase(31);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 31; i++) begin
         checks++;
         if (an !== exp_an(ncyc, lit_0)) begin
            errors++; $display("FAIL lz0_an n=%0d: got %h, exp %h", ncyc, an, exp_an(ncyc, lit_0));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load();
      test_back_to_back();
      test_dig_en();
      test_reset_mid();
      test_lz();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
